// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: fetch FSM states, IF/ID slot layout and
// default widths used by the fetch and decode stages.
package pipeline_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam logic [DEF_DATA_W-1:0] DEF_NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic                  valid;
    logic [DEF_DATA_W-1:0] instr;
    logic [DEF_ADDR_W-1:0] pc;
    logic [DEF_ADDR_W-1:0] pc_plus2;
  } if_id_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched instruction that decode could not
// take yet. Clear wins over write, write wins over read.
module fetch_skid_buffer #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_instr,
  input  logic [ADDR_W-1:0] wr_pc,
  input  logic [ADDR_W-1:0] wr_pc_plus2,
  input  logic              rd,
  output logic              full,
  output logic [DATA_W-1:0] rd_instr,
  output logic [ADDR_W-1:0] rd_pc,
  output logic [ADDR_W-1:0] rd_pc_plus2
);
  import pipeline_pkg::*;

  logic              full_r;
  logic [DATA_W-1:0] instr_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_plus2_r;

  // Entry storage and occupancy flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      full_r     <= 1'b0;
      instr_r    <= {DATA_W{1'b0}};
      pc_r       <= {ADDR_W{1'b0}};
      pc_plus2_r <= {ADDR_W{1'b0}};
    end else if (clear) begin
      full_r <= 1'b0;
    end else if (wr) begin
      full_r     <= 1'b1;
      instr_r    <= wr_instr;
      pc_r       <= wr_pc;
      pc_plus2_r <= wr_pc_plus2;
    end else if (rd) begin
      full_r <= 1'b0;
    end else begin
      full_r <= full_r;
    end
  end

  assign full        = full_r;
  assign rd_instr    = instr_r;
  assign rd_pc       = pc_r;
  assign rd_pc_plus2 = pc_plus2_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: req/ack handshake to instruction memory, IF/ID
// register with a one-entry skid, and flush handling for in-flight requests.
module fetch_stage #(
  parameter int                DATA_W    = pipeline_pkg::DEF_DATA_W,
  parameter int                ADDR_W    = pipeline_pkg::DEF_ADDR_W,
  parameter logic [DATA_W-1:0] NOP_INSTR = pipeline_pkg::DEF_NOP_INSTR
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  input  logic              stall_id,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              pc_hold,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_pc_plus2
);
  import pipeline_pkg::*;

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(2'd2);

  fetch_state_t      state_r;
  fetch_state_t      state_s;
  logic              req_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_plus2_s;
  logic              valid_r;
  logic [DATA_W-1:0] instr_r;
  logic [ADDR_W-1:0] pc_r;
  logic [ADDR_W-1:0] pc_plus2_r;

  logic              accept_s;
  logic              launch_s;
  logic              keep_s;
  logic              load_mem_s;
  logic              skid_wr_s;
  logic              skid_rd_s;
  logic              skid_full_s;
  logic              pc_hold_s;
  logic [DATA_W-1:0] skid_instr_s;
  logic [ADDR_W-1:0] skid_pc_s;
  logic [ADDR_W-1:0] skid_pc_plus2_s;

  assign addr_plus2_s = addr_r + PC_STEP;

  // Next-state and handshake decisions.
  always_comb begin
    accept_s  = !valid_r || !stall_id;
    state_s   = state_r;
    launch_s  = 1'b0;
    keep_s    = 1'b0;
    skid_rd_s = 1'b0;
    case (state_r)
      FETCH: begin
        if (flush) begin
          state_s = FETCH;
        end else if (skid_full_s) begin
          skid_rd_s = accept_s;
        end else if (accept_s) begin
          launch_s = 1'b1;
          state_s  = WAIT;
        end else begin
          state_s = FETCH;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          keep_s  = !flush;
          state_s = FETCH;
        end else if (flush) begin
          state_s = DROP;
        end else begin
          state_s = WAIT;
        end
      end
      DROP: begin
        // The memory still owes an ack; its data is thrown away.
        if (imem_ack) begin
          state_s = FETCH;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = FETCH;
      end
    endcase
    load_mem_s = keep_s && accept_s;
    skid_wr_s  = keep_s && !accept_s;
    pc_hold_s  = reset || !(keep_s || flush);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_s;
    end
  end

  // Request level and its latched address, held until the ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_r  <= 1'b0;
      addr_r <= {ADDR_W{1'b0}};
    end else if (launch_s) begin
      req_r  <= 1'b1;
      addr_r <= pc;
    end else begin
      req_r  <= (state_s == WAIT) || (state_s == DROP);
      addr_r <= addr_r;
    end
  end

  // IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r    <= 1'b0;
      instr_r    <= NOP_INSTR;
      pc_r       <= {ADDR_W{1'b0}};
      pc_plus2_r <= {ADDR_W{1'b0}};
    end else if (flush) begin
      valid_r <= 1'b0;
      instr_r <= NOP_INSTR;
    end else if (load_mem_s) begin
      valid_r    <= 1'b1;
      instr_r    <= imem_rdata;
      pc_r       <= addr_r;
      pc_plus2_r <= addr_plus2_s;
    end else if (skid_rd_s) begin
      valid_r    <= 1'b1;
      instr_r    <= skid_instr_s;
      pc_r       <= skid_pc_s;
      pc_plus2_r <= skid_pc_plus2_s;
    end else begin
      valid_r <= valid_r;
    end
  end

  fetch_skid_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .clear       (flush),
    .wr          (skid_wr_s),
    .wr_instr    (imem_rdata),
    .wr_pc       (addr_r),
    .wr_pc_plus2 (addr_plus2_s),
    .rd          (skid_rd_s),
    .full        (skid_full_s),
    .rd_instr    (skid_instr_s),
    .rd_pc       (skid_pc_s),
    .rd_pc_plus2 (skid_pc_plus2_s)
  );

  assign imem_req       = req_r;
  assign imem_addr      = addr_r;
  assign pc_hold        = pc_hold_s;
  assign if_id_valid    = valid_r;
  assign if_id_instr    = instr_r;
  assign if_id_pc       = pc_r;
  assign if_id_pc_plus2 = pc_plus2_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pc = 16'h0000;
  logic        flush = 1'b0;
  logic        stall_id = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        pc_hold;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_plus2;

  int total = 0;
  int bad = 0;

  // Model: one outstanding memory transaction (possibly doomed by a flush),
  // an optional parked instruction, and the IF/ID slot contents.
  bit          m_out = 1'b0;
  bit          m_doomed = 1'b0;
  logic [15:0] m_addr = 16'h0000;
  bit          m_park = 1'b0;
  logic [15:0] m_park_instr = 16'h0000;
  logic [15:0] m_park_pc = 16'h0000;
  bit          m_v = 1'b0;
  logic [15:0] m_instr = 16'h0000;
  logic [15:0] m_pc = 16'h0000;
  logic [15:0] m_p2 = 16'h0000;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .flush          (flush),
    .stall_id       (stall_id),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .pc_hold        (pc_hold),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus2 (if_id_pc_plus2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    bit          accept;
    bit          got;
    logic [15:0] g_instr;
    logic [15:0] g_pc;
    if (reset) begin
      m_out = 1'b0; m_doomed = 1'b0; m_addr = 16'h0000; m_park = 1'b0;
      m_v = 1'b0; m_instr = 16'h0000; m_pc = 16'h0000; m_p2 = 16'h0000;
    end else begin
      accept  = !m_v || !stall_id;
      got     = 1'b0;
      g_instr = imem_rdata;
      g_pc    = m_addr;
      if (m_out && imem_ack) begin
        m_out = 1'b0;
        got   = !m_doomed && !flush;
      end else if (m_out && flush) begin
        m_doomed = 1'b1;
      end else if (!m_out && !flush) begin
        if (m_park) begin
          if (accept) begin
            m_v = 1'b1; m_instr = m_park_instr; m_pc = m_park_pc;
            m_p2 = m_park_pc + 16'd2; m_park = 1'b0;
          end
        end else if (accept) begin
          m_out = 1'b1; m_doomed = 1'b0; m_addr = pc;
        end
      end
      if (got) begin
        if (accept) begin
          m_v = 1'b1; m_instr = g_instr; m_pc = g_pc; m_p2 = g_pc + 16'd2;
        end else begin
          m_park = 1'b1; m_park_instr = g_instr; m_park_pc = g_pc;
        end
      end
      if (flush) begin
        m_v = 1'b0; m_instr = 16'h0000; m_park = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    bit exp_hold;
    exp_hold = reset || !(flush || (m_out && !m_doomed && imem_ack));
    chk("imem_req", 32'(imem_req), 32'(m_out));
    chk("imem_addr", 32'(imem_addr), 32'(m_addr));
    chk("pc_hold", 32'(pc_hold), 32'(exp_hold));
    chk("if_id_valid", 32'(if_id_valid), 32'(m_v));
    chk("if_id_instr", 32'(if_id_instr), 32'(m_instr));
    chk("if_id_pc", 32'(if_id_pc), 32'(m_pc));
    chk("if_id_pc_plus2", 32'(if_id_pc_plus2), 32'(m_p2));
  endtask

  task automatic cyc(input logic r, input logic [15:0] p, input logic f,
                     input logic s, input logic a, input logic [15:0] d);
    @(posedge clk);
    model_update();
    #1;
    reset = r; pc = p; flush = f; stall_id = s; imem_ack = a; imem_rdata = d;
    @(negedge clk);
    check_all();
  endtask

  task automatic rcyc();
    @(posedge clk);
    model_update();
    #1;
    reset      = ($urandom_range(0, 299) == 0);
    flush      = ($urandom_range(0, 7) == 0);
    stall_id   = ($urandom_range(0, 2) == 0);
    pc         = 16'($urandom_range(0, 65535)) & 16'hFFFE;
    imem_ack   = m_out ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 39) == 0);
    imem_rdata = 16'($urandom_range(0, 65535));
    @(negedge clk);
    check_all();
  endtask

  initial begin
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    cyc(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_hold", 32'(pc_hold), 32'd1);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_instr", 32'(if_id_instr), 32'h0000);
    chk("rst_p2", 32'(if_id_pc_plus2), 32'd0);

    // Zero-wait memory at pc 0.
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("first_noreq", 32'(imem_req), 32'd0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h1234);
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_ack_hold", 32'(pc_hold), 32'd0);
    cyc(1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("first_instr", 32'(if_id_instr), 32'h1234);
    chk("first_model", 32'(m_instr), 32'h1234);
    chk("first_pc", 32'(if_id_pc), 32'h0000);
    chk("first_p2", 32'(if_id_pc_plus2), 32'h0002);
    chk("first_hold_after", 32'(pc_hold), 32'd1);

    // Ack while decode is stalled parks the instruction in the skid.
    cyc(1'b0, 16'h0002, 1'b0, 1'b1, 1'b1, 16'hABCD);
    chk("skid_addr", 32'(imem_addr), 32'h0002);
    chk("skid_ack_hold", 32'(pc_hold), 32'd0);
    cyc(1'b0, 16'h0004, 1'b0, 1'b1, 1'b0, 16'h0000);
    chk("skid_ifid_held", 32'(if_id_instr), 32'h1234);
    cyc(1'b0, 16'h0004, 1'b0, 1'b1, 1'b0, 16'h0000);
    chk("skid_noreq", 32'(imem_req), 32'd0);
    cyc(1'b0, 16'h0004, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("skid_noreq2", 32'(imem_req), 32'd0);
    cyc(1'b0, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("skid_out_instr", 32'(if_id_instr), 32'hABCD);
    chk("skid_out_pc", 32'(if_id_pc), 32'h0002);
    chk("skid_out_p2", 32'(if_id_pc_plus2), 32'h0004);
    chk("skid_out_noreq", 32'(imem_req), 32'd0);

    // Three-cycle memory latency at pc 0x0010.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 16'h0010, 1'b0, 1'b0, (i == 2), 16'h5555);
      chk("lat_req", 32'(imem_req), 32'd1);
      chk("lat_addr", 32'(imem_addr), 32'h0010);
      chk("lat_hold", 32'(pc_hold), (i == 2) ? 32'd0 : 32'd1);
      chk("lat_ifid_held", 32'(if_id_instr), 32'hABCD);
    end
    cyc(1'b0, 16'h0012, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("lat_instr", 32'(if_id_instr), 32'h5555);
    chk("lat_pc", 32'(if_id_pc), 32'h0010);

    // Flush while waiting, ack arrives two cycles later and is dropped.
    cyc(1'b0, 16'h0012, 1'b0, 1'b0, 1'b0, 16'h0000);
    cyc(1'b0, 16'h0012, 1'b1, 1'b0, 1'b0, 16'h0000);
    chk("fl_hold", 32'(pc_hold), 32'd0);
    cyc(1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("drop_valid", 32'(if_id_valid), 32'd0);
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_addr", 32'(imem_addr), 32'h0012);
    cyc(1'b0, 16'h0100, 1'b0, 1'b0, 1'b1, 16'hDEAD);
    chk("drop_ack_hold", 32'(pc_hold), 32'd1);
    cyc(1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("drop_instr", 32'(if_id_instr), 32'h0000);
    chk("drop_done_req", 32'(imem_req), 32'd0);

    // Flush coinciding with ack.
    cyc(1'b0, 16'h0100, 1'b1, 1'b0, 1'b1, 16'hBEEF);
    chk("redir_addr", 32'(imem_addr), 32'h0100);
    chk("flack_hold", 32'(pc_hold), 32'd0);
    cyc(1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("flack_instr", 32'(if_id_instr), 32'h0000);
    chk("flack_valid", 32'(if_id_valid), 32'd0);
    chk("flack_req", 32'(imem_req), 32'd0);

    // Fetch at 0xFFFE wraps pc_plus2.
    cyc(1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b1, 16'h7777);
    cyc(1'b0, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("wrap_pc", 32'(if_id_pc), 32'hFFFE);
    chk("wrap_p2", 32'(if_id_pc_plus2), 32'h0000);

    // Reset during WAIT; the late ack must be ignored.
    cyc(1'b1, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("rstw_req_before", 32'(imem_req), 32'd1);
    cyc(1'b0, 16'h0040, 1'b0, 1'b0, 1'b1, 16'h9999);
    chk("rstw_req", 32'(imem_req), 32'd0);
    chk("rstw_hold", 32'(pc_hold), 32'd1);
    cyc(1'b0, 16'h0040, 1'b0, 1'b0, 1'b0, 16'h0000);
    chk("rstw_valid", 32'(if_id_valid), 32'd0);
    chk("rstw_instr", 32'(if_id_instr), 32'h0000);

    for (int n = 0; n < 4000; n++) begin
      rcyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
